vote_tally_bcd: RTL and testbench

VOTE_TALLY_BCD -- requirements
Module: vote_tally_bcd

---
 rtl/evm_pkg.sv | 35 +++
 rtl/bcd_counter_4d.sv | 47 ++++
 rtl/vote_tally_bcd.sv | 189 ++++++++++++++++++
 tb/tb_vote_tally_bcd.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// Shared types and constants for the electronic voting tally block.
//   NUM_CAND     : number of candidate buttons / per-candidate counters
//   bcd_digit_t  : one BCD digit (0-9 in 4 bits)
//   bcd4_t       : four BCD digits, [0] = ones ... [3] = thousands
//   BCD_MAX      : saturation value of a 4-digit counter (9999)
//   state_t      : ballot FSM states
package evm_pkg;

  localparam int NUM_CAND = 4;
  localparam int CAND_W   = $clog2(NUM_CAND);

  typedef logic [3:0]          bcd_digit_t;
  typedef bcd_digit_t [3:0]    bcd4_t;
  typedef logic [CAND_W-1:0]   cand_idx_t;

  localparam bcd4_t BCD_MAX = 16'h9999;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAST,
    ST_ACK
  } state_t;

  // Index of the set bit in a one-hot candidate vector (caller guarantees one-hot).
  function automatic cand_idx_t onehot_to_idx(input logic [NUM_CAND-1:0] v);
    cand_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (v[i]) idx = cand_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bcd_counter_4d.sv
// Saturating 4-digit BCD counter.
//   clk_100MHz : system clock (rising edge)
//   reset      : asynchronous, active-high; clears the count to 0000
//   inc        : increment by one on the next rising edge
//   count      : current count, 0000-9999, holds at 9999
module bcd_counter_4d
  import evm_pkg::*;
(
  input  logic  clk_100MHz,
  input  logic  reset,
  input  logic  inc,
  output bcd4_t count
);

  bcd4_t count_q;
  bcd4_t count_d;
  logic  carry;

  // Ripple the carry from the ones digit upward; a digit at 9 wraps to 0 and
  // passes the carry on, any other digit absorbs it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    count_d = count_q;
    carry   = inc && (count_q != BCD_MAX);
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count_q[i] == 4'd9) begin
          count_d[i] = 4'd0;
        end else begin
          count_d[i] = count_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/vote_tally_bcd.sv
// Ballot-counting core: debounces the officer enable and candidate buttons,
// runs the IDLE/ARMED/CAST/ACK ballot FSM, keeps per-candidate and total
// saturating BCD counts and drives a registered 4-digit display.
//   clk_100MHz  : system clock, all state on its rising edge
//   reset       : asynchronous, active-high
//   btn_enable  : raw ballot-arm button
//   btn_cand    : raw candidate buttons, bit i = candidate i
//   sw_mode     : 0 = show total ballots, 1 = show candidate sw_sel
//   sw_sel      : candidate shown in results mode
//   ones..thousands : registered BCD display digits
//   ready       : high while a ballot is armed
//   vote_led    : high for ACK_CYCLES after an accepted vote
module vote_tally_bcd
  import evm_pkg::*;
#(
  parameter int DB_CYCLES  = 1_000_000,
  parameter int ACK_CYCLES = 50_000_000
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic                btn_enable,
  input  logic [NUM_CAND-1:0] btn_cand,
  input  logic                sw_mode,
  input  logic [CAND_W-1:0]   sw_sel,
  output logic [3:0]          ones,
  output logic [3:0]          tens,
  output logic [3:0]          hundreds,
  output logic [3:0]          thousands,
  output logic                ready,
  output logic                vote_led
);

  localparam int NUM_BTN = NUM_CAND + 1;
  localparam int DB_W    = $clog2(DB_CYCLES + 1);
  localparam int ACK_W   = $clog2(ACK_CYCLES + 1);

  // Bit 0 is the enable button, bits 1..NUM_CAND are the candidates.
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_pulse;

  assign btn_raw = {btn_cand, btn_enable};

  // ---------------------------------------------------------------------------
  // Per-button synchronizer, debouncer and rising-edge pulse
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    logic            sync1_q, sync2_q;
    logic            db_q, db_d;
    logic            pulse_q, pulse_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // The timer runs only while the synchronized level disagrees with the
    // debounced level; any agreement restarts it, so the level must differ
    // for DB_CYCLES consecutive cycles to be accepted.
    always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync2_q != db_q) begin
        if (cnt_q == DB_W'(DB_CYCLES - 1)) db_d  = sync2_q;
        else                               cnt_d = cnt_q + DB_W'(1);
      end
      pulse_d = db_d & ~db_q;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        db_q    <= 1'b0;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[b];
        sync2_q <= sync1_q;
        db_q    <= db_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end

    assign btn_pulse[b] = pulse_q;
  end

  logic                en_pulse;
  logic [NUM_CAND-1:0] cand_pulse;

  assign en_pulse   = btn_pulse[0];
  assign cand_pulse = btn_pulse[NUM_BTN-1:1];

  // ---------------------------------------------------------------------------
  // Ballot FSM
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  cand_idx_t           sel_q, sel_d;
  logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
  logic [NUM_CAND-1:0] cand_inc;
  logic                total_inc;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ack_cnt_d = ack_cnt_q;
    cand_inc  = '0;
    total_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_pulse && !sw_mode) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        // Switching to results mode abandons the ballot. A candidate press
        // coinciding with an enable pulse, or a multi-button press, is ignored.
        if (sw_mode) begin
          state_d = ST_IDLE;
        end else if (!en_pulse && $onehot(cand_pulse)) begin
          sel_d   = onehot_to_idx(cand_pulse);
          state_d = ST_CAST;
        end
      end
      ST_CAST: begin
        cand_inc[sel_q] = 1'b1;
        total_inc       = 1'b1;
        ack_cnt_d       = '0;
        state_d         = ST_ACK;
      end
      ST_ACK: begin
        if (ack_cnt_q == ACK_W'(ACK_CYCLES - 1)) state_d   = ST_IDLE;
        else                                    ack_cnt_d = ack_cnt_q + ACK_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      ack_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

  assign ready    = (state_q == ST_ARMED);
  assign vote_led = (state_q == ST_ACK);

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  bcd4_t cand_count [NUM_CAND];
  bcd4_t total_count;

  for (genvar c = 0; c < NUM_CAND; c++) begin : g_cand
    bcd_counter_4d u_cnt (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .inc        (cand_inc[c]),
      .count      (cand_count[c])
    );
  end

  bcd_counter_4d u_cnt_total (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .inc        (total_inc),
    .count      (total_count)
  );

  // ---------------------------------------------------------------------------
  // Registered display mux
  // ---------------------------------------------------------------------------
  bcd4_t disp_q, disp_d;

  always_comb begin
    disp_d = sw_mode ? cand_count[sw_sel] : total_count;
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) disp_q <= '0;
    else       disp_q <= disp_d;
  end

  assign ones      = disp_q[0];
  assign tens      = disp_q[1];
  assign hundreds  = disp_q[2];
  assign thousands = disp_q[3];

endmodule

// File: tb/tb_vote_tally_bcd.sv
// Directed self-checking bench for vote_tally_bcd with short debounce and
// acknowledge times. Inputs change just after the falling edge; outputs are
// sampled on the falling edge.
module tb_vote_tally_bcd;

  localparam int DB  = 4;
  localparam int ACK = 8;

  logic       clk_100MHz = 1'b0;
  logic       reset;
  logic       btn_enable;
  logic [3:0] btn_cand;
  logic       sw_mode;
  logic [1:0] sw_sel;
  logic [3:0] ones, tens, hundreds, thousands;
  logic       ready;
  logic       vote_led;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  vote_tally_bcd #(
    .DB_CYCLES  (DB),
    .ACK_CYCLES (ACK)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .btn_enable (btn_enable),
    .btn_cand   (btn_cand),
    .sw_mode    (sw_mode),
    .sw_sel     (sw_sel),
    .ones       (ones),
    .tens       (tens),
    .hundreds   (hundreds),
    .thousands  (thousands),
    .ready      (ready),
    .vote_led   (vote_led)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  function automatic logic [15:0] disp();
    return {thousands, hundreds, tens, ones};
  endfunction

  // Select a display source and let the registered mux settle.
  task automatic show(input logic mode, input logic [1:0] sel);
    sw_mode = mode;
    sw_sel  = sel;
    wait_cycles(2);
  endtask

  // Arm with the enable button, then press one candidate through the whole
  // CAST/ACK sequence and release everything.
  task automatic do_vote(input int idx);
    btn_enable = 1'b1;
    wait_cycles(8);
    btn_enable = 1'b0;
    btn_cand[idx] = 1'b1;
    wait_cycles(20);
    btn_cand = '0;
    wait_cycles(8);
  endtask

  initial begin
    int   led_cycles;
    logic led_seen;
    logic ready_at_led;
    logic ready_seen;

    reset      = 1'b1;
    btn_enable = 1'b0;
    btn_cand   = '0;
    sw_mode    = 1'b0;
    sw_sel     = '0;
    wait_cycles(3);
    check("reset_disp", 32'(disp()), 32'h0000);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_led", 32'(vote_led), 32'd0);
    reset = 1'b0;
    wait_cycles(2);

    // Basic vote for candidate 2 with cycle-accurate acknowledge length.
    btn_enable = 1'b1;
    wait_cycles(8);
    check("armed_ready", 32'(ready), 32'd1);
    btn_enable = 1'b0;
    btn_cand[2] = 1'b1;
    led_cycles   = 0;
    led_seen     = 1'b0;
    ready_at_led = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_100MHz);
      if (vote_led) begin
        if (!led_seen) ready_at_led = ready;
        led_seen = 1'b1;
        led_cycles++;
      end
    end
    btn_cand = '0;
    wait_cycles(8);
    check("ack_len", 32'(led_cycles), 32'd8);
    check("ready_fell", 32'(ready_at_led), 32'd0);
    check("idle_ready", 32'(ready), 32'd0);
    show(1'b1, 2'd2);
    check("cand2_one", 32'(disp()), 32'h0001);
    show(1'b0, 2'd0);
    check("total_one", 32'(disp()), 32'h0001);

    // Candidate press while idle is ignored.
    ready_seen = 1'b0;
    btn_cand[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_100MHz);
      ready_seen |= ready;
    end
    btn_cand = '0;
    wait_cycles(8);
    check("idle_press_ready", 32'(ready_seen), 32'd0);
    check("idle_press_total", 32'(disp()), 32'h0001);

    // Two candidates together are ignored; a later single press counts.
    btn_enable = 1'b1;
    wait_cycles(8);
    btn_enable = 1'b0;
    btn_cand = 4'b0011;
    wait_cycles(20);
    check("double_ready", 32'(ready), 32'd1);
    check("double_total", 32'(disp()), 32'h0001);
    btn_cand = '0;
    wait_cycles(10);
    btn_cand[1] = 1'b1;
    wait_cycles(20);
    btn_cand = '0;
    wait_cycles(8);
    check("single_total", 32'(disp()), 32'h0002);
    show(1'b1, 2'd1);
    check("cand1_one", 32'(disp()), 32'h0001);
    show(1'b1, 2'd0);
    check("cand0_zero", 32'(disp()), 32'h0000);
    show(1'b0, 2'd0);

    // Short glitch is rejected, long press arms.
    btn_enable = 1'b1;
    wait_cycles(3);
    btn_enable = 1'b0;
    wait_cycles(12);
    check("glitch3_ready", 32'(ready), 32'd0);
    btn_enable = 1'b1;
    wait_cycles(6);
    btn_enable = 1'b0;
    wait_cycles(8);
    check("glitch6_ready", 32'(ready), 32'd1);
    // Results mode abandons the armed ballot without counting.
    sw_mode = 1'b1;
    wait_cycles(3);
    check("abort_ready", 32'(ready), 32'd0);
    show(1'b0, 2'd0);
    check("abort_total", 32'(disp()), 32'h0002);

    // Digit ripple and saturation on candidate 3.
    force dut.g_cand[3].u_cnt.count_q = 16'h0999;
    wait_cycles(1);
    release dut.g_cand[3].u_cnt.count_q;
    do_vote(3);
    show(1'b1, 2'd3);
    check("cand3_ripple", 32'(disp()), 32'h1000);
    show(1'b0, 2'd0);
    check("total_three", 32'(disp()), 32'h0003);
    force dut.g_cand[3].u_cnt.count_q = 16'h9999;
    wait_cycles(1);
    release dut.g_cand[3].u_cnt.count_q;
    do_vote(3);
    show(1'b1, 2'd3);
    check("cand3_sat", 32'(disp()), 32'h9999);
    show(1'b0, 2'd0);
    check("total_four", 32'(disp()), 32'h0004);

    // Reset in the middle of ACK clears everything.
    btn_enable = 1'b1;
    wait_cycles(8);
    btn_enable = 1'b0;
    btn_cand[0] = 1'b1;
    wait_cycles(10);
    check("in_ack", 32'(vote_led), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_ack_disp", 32'(disp()), 32'h0000);
    check("rst_ack_led", 32'(vote_led), 32'd0);
    check("rst_ack_ready", 32'(ready), 32'd0);
    btn_cand = '0;
    wait_cycles(2);
    reset = 1'b0;
    show(1'b1, 2'd3);
    check("rst_cand3", 32'(disp()), 32'h0000);
    show(1'b1, 2'd0);
    check("rst_cand0", 32'(disp()), 32'h0000);
    show(1'b0, 2'd0);
    check("rst_total", 32'(disp()), 32'h0000);

    // Button held through reset deassertion acts as a fresh press.
    btn_enable = 1'b1;
    wait_cycles(10);
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    #1;
    check("held_rst_ready0", 32'(ready), 32'd0);
    wait_cycles(8);
    check("held_rst_ready1", 32'(ready), 32'd1);
    btn_enable = 1'b0;
    wait_cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
